// File: rtl/dpwm_pkg.sv
// Shared definitions for the DPWM generator and its capture/loopback checker.
//   dpwm_state_t          : capture FSM state encoding
//   DPWM_RESOLUTION       : default width of counters and measured values
//   DPWM_SYNC_STAGES_MIN  : minimum number of synchronizer flops on async gate inputs
package dpwm_pkg;

  localparam int DPWM_RESOLUTION      = 12;
  localparam int DPWM_SYNC_STAGES_MIN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_C1_HI = 3'd1,
    ST_DT1   = 3'd2,
    ST_C2_HI = 3'd3,
    ST_DT2   = 3'd4
  } dpwm_state_t;

endpackage

// File: rtl/dpwm_edge_sync.sv
// Synchronizes one asynchronous gate signal into the hf_clock domain and
// produces single-cycle rise/fall pulses from the synchronized level.
//   hf_clock : sampling clock
//   reset    : synchronous, active-high; clears all flops
//   din      : asynchronous input
//   level    : synchronized level
//   rise     : high for the first cycle level is 1
//   fall     : high for the first cycle level is 0
module dpwm_edge_sync
  import dpwm_pkg::*;
#(
  parameter int SYNC_STAGES = DPWM_SYNC_STAGES_MIN
) (
  input  logic hf_clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // Fewer than two stages is never metastability-safe, so clamp.
  localparam int STAGES = (SYNC_STAGES < DPWM_SYNC_STAGES_MIN) ? DPWM_SYNC_STAGES_MIN : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              level_d;

  always_ff @(posedge hf_clock) begin
    if (reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      level_d <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/dpwm_capture.sv
// Measures a complementary gate pair (c1 high side, c2 low side) and reports,
// once per switching period, period / c1 on-time / dead-time c1->c2 /
// dead-time c2->c1, all in hf_clock cycles.
//   hf_clock    : sampling clock
//   reset       : synchronous, active-high
//   enable      : 0 forces IDLE and clears counters; outputs hold
//   c1, c2      : asynchronous gate inputs
//   period      : cycles between consecutive c1 rises
//   on_time     : cycles c1 high
//   dt1, dt2    : both-low cycles after c1 fall / after c2 fall
//   meas_valid  : one-cycle pulse when the four values update
//   err_overlap : c1 and c2 were high together in the published period
//   err_sat     : a counter hit all-ones in the published period
//   stalled     : no c1 rise for 2^RESOLUTION-1 cycles; cleared by next c1 rise
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not armed; waiting for the first c1 rise
// ST_C1_HI | c1 high, counting on-time
// ST_DT1   | c1 fallen, waiting for c2 rise (or c1 rise if c2 is absent)
// ST_C2_HI | c2 high
// ST_DT2   | c2 fallen, waiting for c1 rise to close the period
module dpwm_capture
  import dpwm_pkg::*;
#(
  parameter int RESOLUTION  = DPWM_RESOLUTION,
  parameter int SYNC_STAGES = DPWM_SYNC_STAGES_MIN
) (
  input  logic                  hf_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  c1,
  input  logic                  c2,
  output logic [RESOLUTION-1:0] period,
  output logic [RESOLUTION-1:0] on_time,
  output logic [RESOLUTION-1:0] dt1,
  output logic [RESOLUTION-1:0] dt2,
  output logic                  meas_valid,
  output logic                  err_overlap,
  output logic                  err_sat,
  output logic                  stalled
);

  localparam logic [RESOLUTION-1:0] CNT_MAX = '1;
  localparam logic [RESOLUTION-1:0] CNT_ONE = {{(RESOLUTION-1){1'b0}}, 1'b1};

  function automatic logic [RESOLUTION-1:0] sat_inc(input logic [RESOLUTION-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic s1, s1_rise, s1_fall;
  logic s2, s2_rise, s2_fall;

  dpwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c1 (
    .hf_clock(hf_clock), .reset(reset), .din(c1),
    .level(s1), .rise(s1_rise), .fall(s1_fall)
  );

  dpwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c2 (
    .hf_clock(hf_clock), .reset(reset), .din(c2),
    .level(s2), .rise(s2_rise), .fall(s2_fall)
  );

  dpwm_state_t           state, state_nx;
  logic [RESOLUTION-1:0] per_cnt, ph_cnt;
  logic [RESOLUTION-1:0] on_lat, dt1_lat;
  logic                  ovl_flag, sat_flag;

  logic arm, publish, ph_restart, lat_on, lat_dt1, dt1_zero, dt2_zero, go_stall;
  logic per_start, ph_start, cnt_clear, sat_now;

  always_comb begin
    state_nx   = state;
    arm        = 1'b0;
    publish    = 1'b0;
    ph_restart = 1'b0;
    lat_on     = 1'b0;
    lat_dt1    = 1'b0;
    dt1_zero   = 1'b0;
    dt2_zero   = 1'b0;
    go_stall   = 1'b0;
    if (!enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (s1_rise) begin
          arm      = 1'b1;
          state_nx = ST_C1_HI;
        end
        // An s2 rise while c1 is still high is an overlap, not a phase change.
        ST_C1_HI: if (s1_fall) begin
          lat_on     = 1'b1;
          ph_restart = 1'b1;
          if (s2_rise) begin
            dt1_zero = 1'b1;
            state_nx = ST_C2_HI;
          end else begin
            state_nx = ST_DT1;
          end
        end
        ST_DT1: if (s1_rise) begin
          dt2_zero = 1'b1;
          publish  = 1'b1;
          state_nx = ST_C1_HI;
        end else if (s2_rise) begin
          lat_dt1    = 1'b1;
          ph_restart = 1'b1;
          state_nx   = ST_C2_HI;
        end
        ST_C2_HI: if (s2_fall) begin
          if (s1_rise) begin
            dt2_zero = 1'b1;
            publish  = 1'b1;
            state_nx = ST_C1_HI;
          end else begin
            ph_restart = 1'b1;
            state_nx   = ST_DT2;
          end
        end
        ST_DT2: if (s1_rise) begin
          publish  = 1'b1;
          state_nx = ST_C1_HI;
        end
        default: state_nx = ST_IDLE;
      endcase
      // A rise arriving exactly at saturation still closes a legal (max-length) period.
      if (state != ST_IDLE && !publish && per_cnt == CNT_MAX) begin
        go_stall = 1'b1;
        state_nx = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hf_clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  assign per_start = arm | publish;
  assign ph_start  = per_start | ph_restart;
  assign cnt_clear = !enable || go_stall || (state == ST_IDLE && !arm);
  assign sat_now   = (per_cnt == CNT_MAX) || (ph_cnt == CNT_MAX);

  // Counters hold "cycles elapsed in this phase/period so far", so the value
  // seen on the edge-detect cycle is exactly the length of the phase that ends.
  always_ff @(posedge hf_clock) begin
    if (reset || cnt_clear) begin
      per_cnt  <= '0;
      ph_cnt   <= '0;
      ovl_flag <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      per_cnt  <= per_start ? CNT_ONE : sat_inc(per_cnt);
      ph_cnt   <= ph_start  ? CNT_ONE : sat_inc(ph_cnt);
      // The c1-rise cycle belongs to the new period, so its overlap is kept.
      ovl_flag <= (per_start ? 1'b0 : ovl_flag) | (s1 & s2);
      sat_flag <= per_start ? 1'b0 : (sat_flag | sat_now);
    end
  end

  always_ff @(posedge hf_clock) begin
    if (reset) begin
      on_lat  <= '0;
      dt1_lat <= '0;
    end else begin
      if (lat_on)        on_lat  <= ph_cnt;
      if (dt1_zero)      dt1_lat <= '0;
      else if (lat_dt1)  dt1_lat <= ph_cnt;
    end
  end

  always_ff @(posedge hf_clock) begin
    if (reset) begin
      period      <= '0;
      on_time     <= '0;
      dt1         <= '0;
      dt2         <= '0;
      meas_valid  <= 1'b0;
      err_overlap <= 1'b0;
      err_sat     <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        period      <= per_cnt;
        on_time     <= on_lat;
        // Closing from DT1 means c2 never rose: the current phase is dt1.
        dt1         <= (state == ST_DT1) ? ph_cnt : dt1_lat;
        dt2         <= dt2_zero ? '0 : ph_cnt;
        err_overlap <= ovl_flag;
        err_sat     <= sat_flag | sat_now;
      end
      if (go_stall)  stalled <= 1'b1;
      else if (arm)  stalled <= 1'b0;
    end
  end

endmodule
